syscall_sequencer: RTL and testbench
====================================

Name: syscall_sequencer

Overview:
Sequences MIPS syscall service for the single-cycle/pipelined core. When decode flags a syscall, the block freezes the pipeline and captures v0/a0. It then either hands a print request to the console device over a valid/ready handshake, or halts the machine. It also keeps the cycle and retired-instruction counters used for end-of-run statistics, plus error bookkeeping for unsupported or stuck services.

Parameters:
CYC_W, 32, width of cycle_count and inst_count
TIMEOUT, 255, max cycles a print request may wait for out_ready before being dropped (>=1)

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset
syscall_control  input  1  current instruction is a syscall (from control unit)
inst_valid  input  1  an instruction retires this cycle
v0  input  32  register $v0, service code
a0  input  32  register $a0, argument
stall  output  1  freeze PC/pipeline this cycle
out_valid  output  1  console request valid
out_ready  input  1  console accepts request
out_kind  output  2  0 = print integer, 1 = print char, 2/3 reserved
out_data  output  32  console payload
halted  output  1  program exited (v0=10)
cycle_count  output  CYC_W  clock cycles since reset
inst_count  output  CYC_W  retired instructions since reset
unknown_count  output  8  unsupported syscalls seen, saturating
timeout_err  output  1  sticky: a print request timed out

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; out_valid=0, out_kind=0, out_data=0, halted=0, all counters 0, timeout_err=0, wait counter 0. Reset overrides everything, including HALT and a pending PRINT; a pending request is abandoned without handshake.
- States: IDLE, PRINT, HALT.
- IDLE, syscall_control=1, decoded on the v0 value:
  - v0=1: capture out_data=a0, out_kind=0; go to PRINT.
  - v0=11: capture out_data={24'b0,a0[7:0]}, out_kind=1; go to PRINT.
  - v0=10: go to HALT.
  - Any other v0: unknown_count+1, saturating at 255; stay in IDLE with no stall.
- stall in IDLE is combinational: syscall_control & (v0==1 | v0==10 | v0==11). The pipeline therefore freezes in the same cycle the syscall is decoded.
- PRINT:
  - out_valid=1; out_data and out_kind stay stable until the handshake.
  - stall = ~out_ready, so the pipeline advances past the syscall on the handshake cycle.
  - On out_valid&out_ready at posedge: out_valid=0, wait counter cleared, next state IDLE.
  - Wait counter increments each PRINT cycle without ready. When it equals TIMEOUT-1 and out_ready=0: the request is dropped (out_valid=0), timeout_err is set, state returns to IDLE, and stall=0 in that cycle.
  - If out_ready=1 in the same cycle the timeout would fire, the handshake wins and timeout_err is unchanged.
  - syscall_control is ignored while in PRINT.
- HALT: halted=1 from the next cycle onward; stall=1 permanently; out_valid=0; all inputs ignored until reset.
- Handshake latency: out_valid rises one cycle after the syscall is decoded. Minimum syscall cost is 2 cycles: decode cycle plus a handshake cycle with ready already high.
- cycle_count: +1 every cycle when not halted. Wraps modulo 2^CYC_W. Frozen in HALT, and the halting syscall's decode cycle is counted.
- inst_count: +1 when inst_valid & ~stall & ~halted. Wraps modulo 2^CYC_W.
- unknown_count and timeout_err hold their values through HALT.

Test Plan:
- Print int: reset, v0=1, a0=32'd42, syscall_control=1 with out_ready=0 for 3 cycles then 1 -> out_valid high one cycle after decode, out_data=42, out_kind=0, stall high 4 cycles, low on the handshake cycle, state back to IDLE.
- Print char: v0=11, a0=32'h1234_5641, out_ready=1 -> out_data=32'h0000_0041, out_kind=1, exactly one valid cycle, stall high only on the decode cycle.
- Exit: run 20 cycles with inst_valid=1 and no syscalls, then v0=10 -> halted=1 next cycle, stall stuck at 1, cycle_count=21 frozen, inst_count=20 frozen across 50 further cycles.
- Unknown/saturation: 300 syscalls with v0=5 -> unknown_count=255, stall never asserted, no out_valid.
- Timeout: TIMEOUT=4, v0=1, out_ready held 0 -> out_valid dropped after 4 valid cycles, timeout_err=1. Repeat with out_ready=1 on the 4th valid cycle -> handshake completes, timeout_err stays 0.
- Reset mid-op: rst_n=0 while in PRINT and again in HALT -> next cycle out_valid=0, halted=0, stall=0, all counters 0.

Source files
------------

// File: rtl/syscall_sequencer.sv
// MIPS syscall service sequencer: freezes the pipeline on a syscall, forwards print
// requests to the console over valid/ready, halts on exit, and keeps run statistics.
module syscall_sequencer #(
    parameter int CYC_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             syscall_control,
    input  logic             inst_valid,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    output logic             stall,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_kind,
    output logic [31:0]      out_data,
    output logic             halted,
    output logic [CYC_W-1:0] cycle_count,
    output logic [CYC_W-1:0] inst_count,
    output logic [7:0]       unknown_count,
    output logic             timeout_err
);

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRINT, S_HALT} state_t;

    state_t             r_state;
    logic               r_out_valid;
    logic [1:0]         r_out_kind;
    logic [31:0]        r_out_data;
    logic               r_halted;
    logic [CYC_W-1:0]   r_cycle_count;
    logic [CYC_W-1:0]   r_inst_count;
    logic [7:0]         r_unknown_count;
    logic               r_timeout_err;
    logic [WAIT_W-1:0]  r_wait;

    logic w_svc_int;
    logic w_svc_char;
    logic w_svc_exit;
    logic w_svc_known;
    logic w_timeout;
    logic w_stall;

    assign w_svc_int   = (v0 == 32'd1);
    assign w_svc_char  = (v0 == 32'd11);
    assign w_svc_exit  = (v0 == 32'd10);
    assign w_svc_known = w_svc_int | w_svc_char | w_svc_exit;
    assign w_timeout   = (r_state == S_PRINT) && !out_ready && (r_wait == WAIT_LAST);

    // The drop cycle releases the pipeline just like a handshake would.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = syscall_control & w_svc_known;
            S_PRINT: w_stall = ~out_ready & ~w_timeout;
            S_HALT:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_out_valid     <= 1'b0;
            r_out_kind      <= 2'd0;
            r_out_data      <= 32'd0;
            r_halted        <= 1'b0;
            r_cycle_count   <= '0;
            r_inst_count    <= '0;
            r_unknown_count <= 8'd0;
            r_timeout_err   <= 1'b0;
            r_wait          <= '0;
        end else begin
            if (!r_halted)
                r_cycle_count <= r_cycle_count + 1'b1;
            if (inst_valid && !w_stall && !r_halted)
                r_inst_count <= r_inst_count + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (syscall_control) begin
                        if (w_svc_int) begin
                            r_out_data  <= a0;
                            r_out_kind  <= 2'd0;
                            r_out_valid <= 1'b1;
                            r_wait      <= '0;
                            r_state     <= S_PRINT;
                        end else if (w_svc_char) begin
                            r_out_data  <= {24'b0, a0[7:0]};
                            r_out_kind  <= 2'd1;
                            r_out_valid <= 1'b1;
                            r_wait      <= '0;
                            r_state     <= S_PRINT;
                        end else if (w_svc_exit) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else if (r_unknown_count != 8'hFF) begin
                            r_unknown_count <= r_unknown_count + 8'd1;
                        end
                    end
                end
                S_PRINT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_wait      <= '0;
                        r_state     <= S_IDLE;
                    end else if (r_wait == WAIT_LAST) begin
                        r_out_valid   <= 1'b0;
                        r_wait        <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_HALT: begin
                    r_out_valid <= 1'b0;
                    r_halted    <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall         = w_stall;
    assign out_valid     = r_out_valid;
    assign out_kind      = r_out_kind;
    assign out_data      = r_out_data;
    assign halted        = r_halted;
    assign cycle_count   = r_cycle_count;
    assign inst_count    = r_inst_count;
    assign unknown_count = r_unknown_count;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_syscall_sequencer.sv
// Directed testbench for syscall_sequencer (TIMEOUT=4) with hand-computed expectations.
module tb_syscall_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        syscall_control;
    logic        inst_valid;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [31:0] out_data;
    logic        halted;
    logic [31:0] cycle_count;
    logic [31:0] inst_count;
    logic [7:0]  unknown_count;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    syscall_sequencer #(.CYC_W(32), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .syscall_control(syscall_control),
        .inst_valid     (inst_valid),
        .v0             (v0),
        .a0             (a0),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_kind       (out_kind),
        .out_data       (out_data),
        .halted         (halted),
        .cycle_count    (cycle_count),
        .inst_count     (inst_count),
        .unknown_count  (unknown_count),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; syscall_control = 1'b0; inst_valid = 1'b0;
        v0 = 32'd0; a0 = 32'd0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_kind !== 2'd0) begin n_errors++; $display("FAIL rst_kind: got %0d expected 0", out_kind); end
        n_checks++; if (out_data !== 32'd0) begin n_errors++; $display("FAIL rst_data: got %0d expected 0", out_data); end
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b expected 0", stall); end
        n_checks++; if (cycle_count !== 32'd0) begin n_errors++; $display("FAIL rst_cycle: got %0d expected 0", cycle_count); end
        n_checks++; if (inst_count !== 32'd0) begin n_errors++; $display("FAIL rst_inst: got %0d expected 0", inst_count); end
        n_checks++; if (unknown_count !== 8'd0) begin n_errors++; $display("FAIL rst_unknown: got %0d expected 0", unknown_count); end
        n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL rst_timeout: got %b expected 0", timeout_err); end
    endtask

    task automatic test_print_int();
        int stall_cycles;
        do_reset();
        syscall_control = 1'b1; v0 = 32'd1; a0 = 32'd42; out_ready = 1'b0;
        #1;
        stall_cycles = 0;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL pi_decode_stall: got %b expected 1", stall); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL pi_decode_valid: got %b expected 0", out_valid); end
        if (stall === 1'b1) stall_cycles++;
        tick();
        syscall_control = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL pi_valid: got %b expected 1", out_valid); end
            n_checks++; if (out_data !== 32'd42) begin n_errors++; $display("FAIL pi_data: got %0d expected 42", out_data); end
            n_checks++; if (out_kind !== 2'd0) begin n_errors++; $display("FAIL pi_kind: got %0d expected 0", out_kind); end
            if (stall === 1'b1) stall_cycles++;
            tick();
        end
        n_checks++; if (stall_cycles != 4) begin n_errors++; $display("FAIL pi_stall_cycles: got %0d expected 4", stall_cycles); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL pi_hs_stall: got %b expected 0", stall); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL pi_hs_valid: got %b expected 1", out_valid); end
        tick();
        out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL pi_after_valid: got %b expected 0", out_valid); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL pi_after_stall: got %b expected 0", stall); end
        n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL pi_timeout_err: got %b expected 0", timeout_err); end
    endtask

    task automatic test_print_char();
        int valid_cycles;
        do_reset();
        syscall_control = 1'b1; v0 = 32'd11; a0 = 32'h1234_5641; out_ready = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL pc_decode_stall: got %b expected 1", stall); end
        tick();
        syscall_control = 1'b0;
        #1;
        n_checks++; if (out_data !== 32'h0000_0041) begin n_errors++; $display("FAIL pc_data: got %h expected 00000041", out_data); end
        n_checks++; if (out_kind !== 2'd1) begin n_errors++; $display("FAIL pc_kind: got %0d expected 1", out_kind); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL pc_hs_stall: got %b expected 0", stall); end
        valid_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid === 1'b1) valid_cycles++;
            tick();
            #1;
        end
        n_checks++; if (valid_cycles != 1) begin n_errors++; $display("FAIL pc_valid_cycles: got %0d expected 1", valid_cycles); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        inst_valid = 1'b1; out_ready = 1'b1;
        syscall_control = 1'b1; v0 = 32'd1; a0 = 32'd100;
        tick();
        v0 = 32'd11; a0 = 32'h0000_005A;
        #1;
        n_checks++; if (out_data !== 32'd100) begin n_errors++; $display("FAIL b2b_data1: got %0d expected 100", out_data); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL b2b_hs1_stall: got %b expected 0", stall); end
        tick();
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL b2b_decode2_stall: got %b expected 1", stall); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_gap_valid: got %b expected 0", out_valid); end
        tick();
        syscall_control = 1'b0;
        #1;
        n_checks++; if (out_data !== 32'h0000_005A || out_kind !== 2'd1 || out_valid !== 1'b1)
            begin n_errors++; $display("FAIL b2b_req2: got data %h kind %0d valid %b expected 0000005a 1 1", out_data, out_kind, out_valid); end
        tick();
        #1;
        n_checks++; if (inst_count !== 32'd2) begin n_errors++; $display("FAIL b2b_inst: got %0d expected 2", inst_count); end
        n_checks++; if (cycle_count !== 32'd4) begin n_errors++; $display("FAIL b2b_cycle: got %0d expected 4", cycle_count); end
        inst_valid = 1'b0;
    endtask

    task automatic test_exit();
        do_reset();
        inst_valid = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        syscall_control = 1'b1; v0 = 32'd10;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL ex_decode_stall: got %b expected 1", stall); end
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL ex_early_halt: got %b expected 0", halted); end
        tick();
        v0 = 32'd1; out_ready = 1'b1;
        #1;
        n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL ex_halted: got %b expected 1", halted); end
        n_checks++; if (cycle_count !== 32'd21) begin n_errors++; $display("FAIL ex_cycle: got %0d expected 21", cycle_count); end
        n_checks++; if (inst_count !== 32'd20) begin n_errors++; $display("FAIL ex_inst: got %0d expected 20", inst_count); end
        for (int k = 0; k < 50; k++) begin
            v0 = (k % 2 == 0) ? 32'd1 : 32'd5;
            #1;
            n_checks++; if (stall !== 1'b1 || out_valid !== 1'b0 || halted !== 1'b1)
                begin n_errors++; $display("FAIL ex_hold cyc %0d: got stall %b valid %b halted %b expected 1 0 1", k, stall, out_valid, halted); end
            tick();
        end
        n_checks++; if (cycle_count !== 32'd21) begin n_errors++; $display("FAIL ex_cycle_frozen: got %0d expected 21", cycle_count); end
        n_checks++; if (inst_count !== 32'd20) begin n_errors++; $display("FAIL ex_inst_frozen: got %0d expected 20", inst_count); end
        n_checks++; if (unknown_count !== 8'd0) begin n_errors++; $display("FAIL ex_unknown_frozen: got %0d expected 0", unknown_count); end
    endtask

    task automatic test_unknown();
        do_reset();
        syscall_control = 1'b1; v0 = 32'd5;
        for (int k = 0; k < 300; k++) begin
            #1;
            n_checks++; if (stall !== 1'b0 || out_valid !== 1'b0)
                begin n_errors++; $display("FAIL unk_quiet %0d: got stall %b valid %b expected 0 0", k, stall, out_valid); end
            tick();
            if (k == 99) begin
                n_checks++; if (unknown_count !== 8'd100) begin n_errors++; $display("FAIL unk_100: got %0d expected 100", unknown_count); end
            end
        end
        n_checks++; if (unknown_count !== 8'd255) begin n_errors++; $display("FAIL unk_sat: got %0d expected 255", unknown_count); end
        syscall_control = 1'b0;
    endtask

    task automatic test_timeout();
        int nvalid;
        do_reset();
        syscall_control = 1'b1; v0 = 32'd1; a0 = 32'd7; out_ready = 1'b0;
        tick();
        syscall_control = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid !== 1'b1) break;
            nvalid++;
            n_checks++; if (stall !== (nvalid == 4 ? 1'b0 : 1'b1))
                begin n_errors++; $display("FAIL to_stall valid cycle %0d: got %b expected %b", nvalid, stall, (nvalid == 4 ? 1'b0 : 1'b1)); end
            tick();
        end
        n_checks++; if (nvalid != 4) begin n_errors++; $display("FAIL to_valid_cycles: got %0d expected 4", nvalid); end
        n_checks++; if (timeout_err !== 1'b1) begin n_errors++; $display("FAIL to_err: got %b expected 1", timeout_err); end

        do_reset();
        syscall_control = 1'b1; v0 = 32'd1; a0 = 32'd8; out_ready = 1'b0;
        tick();
        syscall_control = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b1 || stall !== 1'b0)
            begin n_errors++; $display("FAIL to_race_cycle: got valid %b stall %b expected 1 0", out_valid, stall); end
        tick();
        out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL to_race_done: got %b expected 0", out_valid); end
        n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL to_race_err: got %b expected 0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inst_valid = 1'b1;
        syscall_control = 1'b1; v0 = 32'd1; a0 = 32'd9; out_ready = 1'b0;
        tick();
        syscall_control = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; inst_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || halted !== 1'b0 || stall !== 1'b0)
            begin n_errors++; $display("FAIL rm_print_flags: got valid %b halted %b stall %b expected 0 0 0", out_valid, halted, stall); end
        n_checks++; if (cycle_count !== 32'd0 || inst_count !== 32'd0)
            begin n_errors++; $display("FAIL rm_print_counts: got cycle %0d inst %0d expected 0 0", cycle_count, inst_count); end

        syscall_control = 1'b1; v0 = 32'd10;
        tick();
        syscall_control = 1'b0;
        tick();
        #1;
        n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL rm_halt_entered: got %b expected 1", halted); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || halted !== 1'b0 || stall !== 1'b0)
            begin n_errors++; $display("FAIL rm_halt_flags: got valid %b halted %b stall %b expected 0 0 0", out_valid, halted, stall); end
        n_checks++; if (cycle_count !== 32'd0 || inst_count !== 32'd0 || unknown_count !== 8'd0 || timeout_err !== 1'b0)
            begin n_errors++; $display("FAIL rm_halt_counts: got cycle %0d inst %0d unk %0d terr %b expected 0 0 0 0", cycle_count, inst_count, unknown_count, timeout_err); end
    endtask

    initial begin
        test_reset();
        test_print_int();
        test_print_char();
        test_back_to_back();
        test_exit();
        test_unknown();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
